escalonador_pedidos: RTL and testbench

- Request scheduler feeding the SmartCargo movement control unit.
- Arbitrates transport orders (origin floor, destination floor) from two requesters: the floor panel (A) and the remote/serial link (B).
- Queues accepted orders and presents the current target floor to the movement controller as tem_destino / sobe / eh_origem / chegou_destino.
- Advances one phase (origin, then destination) per shift pulse from the controller.

---
 rtl/escalonador_pedidos_pkg.sv | 16 +
 rtl/escalonador_pedidos_fila.sv | 52 +++++
 rtl/escalonador_pedidos.sv | 111 +++++++++++
 tb/tb_escalonador_pedidos.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/escalonador_pedidos_pkg.sv
// Shared types and defaults for the SmartCargo order scheduler.
package escalonador_pkg;
    localparam int ANDAR_W_PADRAO   = 2;
    localparam int N_ANDARES_PADRAO = 4;

    typedef enum logic [1:0] {
        VAZIO   = 2'b00,
        ORIGEM  = 2'b01,
        DESTINO = 2'b10
    } estado_t;

    typedef struct packed {
        logic [ANDAR_W_PADRAO-1:0] origem;
        logic [ANDAR_W_PADRAO-1:0] destino;
    } pedido_t;
endpackage

// File: rtl/escalonador_pedidos_fila.sv
// Order FIFO: head is read straight from storage, so it has no read latency.
module fila_pedidos
    import escalonador_pkg::*;
#(
    parameter type T     = pedido_t,
    parameter int  DEPTH = 8
) (
    input  logic                       clock,
    input  logic                       limpa,
    input  logic                       push,
    input  logic                       pop,
    input  T                           dado,
    output T                           cabeca,
    output logic [$clog2(DEPTH+1)-1:0] ocupacao,
    output logic                       cheia,
    output logic                       vazia
);
    localparam int AW = $clog2(DEPTH);
    localparam int OW = $clog2(DEPTH+1);
    localparam logic [OW-1:0] CHEIO = OW'(DEPTH);

    T mem [DEPTH];
    logic [AW-1:0] wptr, rptr;
    logic push_ok, pop_ok;

    assign push_ok = push & ~cheia;
    assign pop_ok  = pop & ~vazia;
    assign cabeca  = mem[rptr];
    assign cheia   = (ocupacao == CHEIO);
    assign vazia   = (ocupacao == '0);

    // Storage is left unreset so it can map onto plain RAM.
    always_ff @(posedge clock) begin
        if (push_ok) mem[wptr] <= dado;
    end

    always_ff @(posedge clock) begin
        if (limpa) begin
            wptr     <= '0;
            rptr     <= '0;
            ocupacao <= '0;
        end else begin
            if (push_ok) wptr <= wptr + 1'b1;
            if (pop_ok)  rptr <= rptr + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   ocupacao <= ocupacao + 1'b1;
                2'b01:   ocupacao <= ocupacao - 1'b1;
                default: ocupacao <= ocupacao;
            endcase
        end
    end
endmodule

// File: rtl/escalonador_pedidos.sv
// Order scheduler: round-robin arbiter, order validation, queue and origin/destination phase FSM.
module escalonador_pedidos
    import escalonador_pkg::*;
#(
    parameter int N_ANDARES = N_ANDARES_PADRAO,
    parameter int ANDAR_W   = ANDAR_W_PADRAO,
    parameter int DEPTH     = 8
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       limpa,
    input  logic                       req_a_valid,
    input  logic [ANDAR_W-1:0]         req_a_origem,
    input  logic [ANDAR_W-1:0]         req_a_destino,
    output logic                       req_a_ack,
    input  logic                       req_b_valid,
    input  logic [ANDAR_W-1:0]         req_b_origem,
    input  logic [ANDAR_W-1:0]         req_b_destino,
    output logic                       req_b_ack,
    input  logic [ANDAR_W-1:0]         andar_atual,
    input  logic                       shift,
    output logic                       tem_destino,
    output logic [ANDAR_W-1:0]         destino,
    output logic                       sobe,
    output logic                       eh_origem,
    output logic                       chegou_destino,
    output logic                       fila_cheia,
    output logic                       fila_vazia,
    output logic [$clog2(DEPTH+1)-1:0] ocupacao,
    output logic                       erro_pedido,
    output logic [1:0]                 estado_db
);
    localparam int OW = $clog2(DEPTH+1);
    localparam logic [ANDAR_W:0] LIMITE = N_ANDARES[ANDAR_W:0];

    typedef struct packed {
        logic [ANDAR_W-1:0] origem;
        logic [ANDAR_W-1:0] destino;
    } pedido_l_t;

    estado_t   estado;
    logic      rr;
    pedido_l_t cab, escolhido;
    logic      limpar, grant_a, grant_b, grant, valido, push, pop;
    logic [OW-1:0] ocup_prox;

    assign limpar = reset | limpa;

    // Full is judged on the registered count: a same-cycle pop never frees a slot early.
    always_comb begin
        grant_a = 1'b0;
        grant_b = 1'b0;
        if (!limpar && !fila_cheia) begin
            if (req_a_valid && (!req_b_valid || !rr)) grant_a = 1'b1;
            else if (req_b_valid)                     grant_b = 1'b1;
        end
    end

    assign grant     = grant_a | grant_b;
    assign escolhido = grant_a ? {req_a_origem, req_a_destino} : {req_b_origem, req_b_destino};
    assign valido    = (escolhido.origem != escolhido.destino) &&
                       ({1'b0, escolhido.origem} < LIMITE) &&
                       ({1'b0, escolhido.destino} < LIMITE);
    assign push        = grant & valido;
    assign erro_pedido = grant & ~valido;
    assign req_a_ack   = grant_a;
    assign req_b_ack   = grant_b;
    assign pop         = (estado == DESTINO) & shift & ~limpar;
    assign ocup_prox   = ocupacao - OW'(pop) + OW'(push);

    fila_pedidos #(.T(pedido_l_t), .DEPTH(DEPTH)) u_fila (
        .clock    (clock),
        .limpa    (limpar),
        .push     (push),
        .pop      (pop),
        .dado     (escolhido),
        .cabeca   (cab),
        .ocupacao (ocupacao),
        .cheia    (fila_cheia),
        .vazia    (fila_vazia)
    );

    always_ff @(posedge clock) begin
        if (limpar) begin
            estado <= VAZIO;
            rr     <= 1'b0;
        end else begin
            if (grant) rr <= ~rr;
            case (estado)
                VAZIO:   if (ocupacao != '0) estado <= ORIGEM;
                ORIGEM:  if (shift) estado <= DESTINO;
                DESTINO: if (shift) estado <= (ocup_prox != '0) ? ORIGEM : VAZIO;
                default: estado <= VAZIO;
            endcase
        end
    end

    always_comb begin
        case (estado)
            ORIGEM:  destino = cab.origem;
            DESTINO: destino = cab.destino;
            default: destino = '0;
        endcase
    end

    assign estado_db      = estado;
    assign tem_destino    = (estado != VAZIO);
    assign eh_origem      = (estado == ORIGEM);
    assign sobe           = tem_destino && (destino > andar_atual);
    assign chegou_destino = tem_destino && (destino == andar_atual);
endmodule

// File: tb/tb_escalonador_pedidos.sv
// Scoreboard bench: queue-level reference model predicts acks and target outputs per cycle.
module tb_escalonador_pedidos;
    localparam int W = 3;
    localparam int N = 4;
    localparam int D = 8;

    logic clock = 0;
    logic reset = 1, limpa = 0, shift = 0;
    logic req_a_valid = 0, req_b_valid = 0;
    logic [W-1:0] req_a_origem = 0, req_a_destino = 0, req_b_origem = 0, req_b_destino = 0;
    logic [W-1:0] andar_atual = 0;
    logic req_a_ack, req_b_ack, tem_destino, sobe, eh_origem, chegou_destino;
    logic fila_cheia, fila_vazia, erro_pedido;
    logic [W-1:0] destino;
    logic [3:0] ocupacao;
    logic [1:0] estado_db;

    escalonador_pedidos #(.N_ANDARES(N), .ANDAR_W(W), .DEPTH(D)) dut (
        .clock(clock), .reset(reset), .limpa(limpa),
        .req_a_valid(req_a_valid), .req_a_origem(req_a_origem), .req_a_destino(req_a_destino), .req_a_ack(req_a_ack),
        .req_b_valid(req_b_valid), .req_b_origem(req_b_origem), .req_b_destino(req_b_destino), .req_b_ack(req_b_ack),
        .andar_atual(andar_atual), .shift(shift),
        .tem_destino(tem_destino), .destino(destino), .sobe(sobe), .eh_origem(eh_origem),
        .chegou_destino(chegou_destino), .fila_cheia(fila_cheia), .fila_vazia(fila_vazia),
        .ocupacao(ocupacao), .erro_pedido(erro_pedido), .estado_db(estado_db)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [2:0]  acks;
        logic [14:0] st;
    } exp_t;
    typedef struct {
        int o;
        int d;
    } ped_m;

    exp_t exp_q[$];
    ped_m mq[$];
    int   mph = 0;
    bit   mrr = 0;
    bit   last_ga, last_gb;
    int   checks = 0, errors = 0, cyc = 0;

    always @(posedge clock) cyc++;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] expv);
        checks++;
        if (got !== expv) begin
            errors++;
            $display("FAIL %s cycle %0d got %h expected %h", nm, cyc, got, expv);
        end
    endtask

    // Monitor: compares whatever the DUT shows against the oldest prediction.
    initial forever begin
        exp_t e;
        @(negedge clock);
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("acks{a,b,erro}", 32'({req_a_ack, req_b_ack, erro_pedido}), 32'(e.acks));
            chk("status{tem,dst,sobe,eo,cheg,ocup,cheia,vazia,est}",
                32'({tem_destino, destino, sobe, eh_origem, chegou_destino, ocupacao,
                     fila_cheia, fila_vazia, estado_db}), 32'(e.st));
        end
    end

    // Predicts this cycle's outputs, then advances the model across the clock edge.
    task automatic step(input bit do_chk);
        exp_t e;
        bit ga = 0, gb = 0, ok, popn;
        int o, d, dest, n;
        n = mq.size();
        if (!(reset || limpa) && n < D) begin
            if (req_a_valid && (!req_b_valid || !mrr)) ga = 1;
            else if (req_b_valid)                       gb = 1;
        end
        o  = ga ? int'(req_a_origem)  : int'(req_b_origem);
        d  = ga ? int'(req_a_destino) : int'(req_b_destino);
        ok = (ga || gb) && o != d && o < N && d < N;
        dest = (mph == 1) ? mq[0].o : (mph == 2) ? mq[0].d : 0;
        e.acks = {ga, gb, (ga || gb) && !ok};
        e.st = {mph != 0, 3'(dest), dest > int'(andar_atual), mph == 1,
                mph != 0 && dest == int'(andar_atual), 4'(n), n == D, n == 0, 2'(mph)};
        if (do_chk) exp_q.push_back(e);
        @(posedge clock);
        if (reset || limpa) begin
            mq.delete();
            mph = 0;
            mrr = 0;
        end else begin
            if (ga || gb) mrr = !mrr;
            popn = (mph == 2) && shift;
            if (popn) void'(mq.pop_front());
            if (ok) mq.push_back('{o, d});
            case (mph)
                0: if (n != 0) mph = 1;
                1: if (shift) mph = 2;
                default: if (shift) mph = (mq.size() != 0) ? 1 : 0;
            endcase
        end
        last_ga = ga;
        last_gb = gb;
        #1;
    endtask

    task automatic new_a(input bit bad_ok);
        int o;
        o = $urandom_range(0, N-1);
        req_a_valid = 1;
        req_a_origem = W'(o);
        req_a_destino = W'((o + $urandom_range(1, N-1)) % N);
        if (bad_ok && $urandom_range(0, 5) == 0) begin
            req_a_origem = W'($urandom_range(0, 7));
            req_a_destino = ($urandom_range(0, 1) == 0) ? req_a_origem : W'($urandom_range(N, 7));
        end
    endtask

    task automatic new_b(input bit bad_ok);
        int o;
        o = $urandom_range(0, N-1);
        req_b_valid = 1;
        req_b_origem = W'(o);
        req_b_destino = W'((o + $urandom_range(1, N-1)) % N);
        if (bad_ok && $urandom_range(0, 5) == 0) begin
            req_b_origem = W'($urandom_range(0, 7));
            req_b_destino = ($urandom_range(0, 1) == 0) ? req_b_origem : W'($urandom_range(N, 7));
        end
    endtask

    task automatic do_reset();
        req_a_valid = 0; req_b_valid = 0; shift = 0; limpa = 0;
        reset = 1;
        step(1);
        reset = 0;
    endtask

    task automatic clear_during_destino(input bit use_reset);
        do_reset();
        for (int i = 0; i < 3; i++) begin
            new_a(0);
            step(1);
        end
        req_a_valid = 0;
        step(1);
        shift = 1;
        step(1);
        shift = 0;
        new_a(0);
        if (use_reset) reset = 1; else limpa = 1;
        step(1);
        reset = 0; limpa = 0; req_a_valid = 0;
        step(1);
        step(1);
    endtask

    initial begin
        step(0);
        step(1);
        reset = 0;

        // Single order walk-through.
        req_a_valid = 1; req_a_origem = 1; req_a_destino = 3; andar_atual = 0;
        step(1);
        req_a_valid = 0;
        step(1);
        step(1);
        andar_atual = 1;
        step(1);
        shift = 1;
        step(1);
        shift = 0;
        step(1);
        shift = 1;
        step(1);
        shift = 0;
        step(1);

        // Both requesters contend: alternating grants.
        do_reset();
        new_a(0); new_b(0);
        for (int i = 0; i < 4; i++) begin
            step(1);
            if (last_ga) new_a(0);
            if (last_gb) new_b(0);
        end
        req_a_valid = 0; req_b_valid = 0;
        step(1);

        // Rejected orders.
        do_reset();
        req_a_valid = 1; req_a_origem = 2; req_a_destino = 2;
        step(1);
        req_a_origem = 0; req_a_destino = 5;
        step(1);
        req_a_valid = 0;
        step(1);
        step(1);

        // Fill, hold, pop, and push coinciding with pop.
        do_reset();
        for (int i = 0; i < D; i++) begin
            new_a(0);
            step(1);
        end
        new_a(0);
        step(1);
        step(1);
        shift = 1;
        step(1);
        step(1);
        shift = 0;
        step(1);
        req_a_valid = 0;
        shift = 1;
        step(1);
        step(1);
        shift = 0;
        step(1);
        shift = 1;
        step(1);
        new_a(0);
        step(1);
        shift = 0; req_a_valid = 0;
        step(1);

        clear_during_destino(0);
        clear_during_destino(1);

        // Randomised traffic.
        for (int i = 0; i < 600; i++) begin
            if (!req_a_valid || last_ga) begin
                if ($urandom_range(0, 9) < 7) new_a(1); else req_a_valid = 0;
            end
            if (!req_b_valid || last_gb) begin
                if ($urandom_range(0, 9) < 7) new_b(1); else req_b_valid = 0;
            end
            shift = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 3) == 0) andar_atual = W'($urandom_range(0, N-1));
            limpa = ($urandom_range(0, 79) == 0);
            reset = ($urandom_range(0, 149) == 0);
            step(1);
        end
        reset = 0; limpa = 0; shift = 0; req_a_valid = 0; req_b_valid = 0;
        step(0);
        step(0);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
